// File: rtl/future_sbox_pkg.sv
// Shared tables and lookup helpers for the FUTURE cipher 4-bit S-box.
// The inverse helper is built only when FUTURE_SB_INVERSE_EN is defined.
package future_sbox_pkg;

    localparam int SBOX_W = 4;

    localparam logic [SBOX_W-1:0] SBOX_FWD [16] = '{
        4'h1, 4'h3, 4'h0, 4'h2, 4'h7, 4'hE, 4'h4, 4'hD,
        4'h9, 4'hB, 4'h8, 4'hA, 4'hF, 4'h6, 4'hC, 4'h5
    };

    localparam logic [SBOX_W-1:0] SBOX_INV [16] = '{
        4'h2, 4'h0, 4'h3, 4'h1, 4'h6, 4'hF, 4'hD, 4'h4,
        4'hA, 4'h8, 4'hB, 4'h9, 4'hE, 4'h7, 4'h5, 4'hC
    };

    function automatic logic [SBOX_W-1:0] sbox_fwd(input logic [SBOX_W-1:0] x);
        return SBOX_FWD[x];
    endfunction

`ifdef FUTURE_SB_INVERSE_EN
    function automatic logic [SBOX_W-1:0] sbox_inv(input logic [SBOX_W-1:0] x);
        return SBOX_INV[x];
    endfunction
`endif

endpackage

// File: rtl/future_sbox_lut.sv
// Combinational 4-in/4-out FUTURE S-box table.
// With FUTURE_SB_INVERSE_EN the inv input selects the inverse table.
module future_sbox_lut
    import future_sbox_pkg::*;
(
    input  logic [SBOX_W-1:0] x,
`ifdef FUTURE_SB_INVERSE_EN
    input  logic              inv,
`endif
    output logic [SBOX_W-1:0] y
);

`ifdef FUTURE_SB_INVERSE_EN
    always_comb begin
        y = sbox_fwd(x);
        if (inv) begin
            y = sbox_inv(x);
        end
    end
`else
    always_comb begin
        y = sbox_fwd(x);
    end
`endif

endmodule

// File: rtl/future_sbox.sv
// FUTURE cipher S-box with one cycle of registered latency, one per round nibble.
// Optional inverse table and inv port enabled by FUTURE_SB_INVERSE_EN.
module future_sbox
    import future_sbox_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
`ifdef FUTURE_SB_INVERSE_EN
    input  logic inv,
`endif
    output logic out_valid,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3
);

    // Valid-only stream: a nibble is taken on every edge where in_valid=1,
    // out_valid follows one cycle later, and there is no backpressure.
    logic [SBOX_W-1:0] w_x;
    logic [SBOX_W-1:0] w_sub;
    logic [SBOX_W-1:0] r_y;
    logic              r_valid;

    assign w_x = {x3, x2, x1, x0};

    future_sbox_lut u_lut (
        .x   (w_x),
`ifdef FUTURE_SB_INVERSE_EN
        .inv (inv),
`endif
        .y   (w_sub)
    );

    // y loads only on valid edges, so idle-cycle inputs never reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_sub;
            end
        end
    end

    assign out_valid = r_valid;
    assign {y3, y2, y1, y0} = r_y;

endmodule

// File: tb/tb_future_sbox.sv
// Directed self-checking bench for future_sbox; inverse tests compile in
// when FUTURE_SB_INVERSE_EN is defined.
module tb_future_sbox;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic x0, x1, x2, x3;
  logic out_valid;
  logic y0, y1, y2, y3;
`ifdef FUTURE_SB_INVERSE_EN
  logic inv;
`endif

  int checks;
  int errors;
  logic [3:0] exp_q[$];
  logic [3:0] fwd_tab [16];
  logic [15:0] seen;
  int repeats;

  future_sbox dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
`ifdef FUTURE_SB_INVERSE_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] y_bus();
    return {y3, y2, y1, y0};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs at the falling edge so the next rising edge samples them
  task automatic drive(input logic v, input logic [3:0] x);
    @(negedge clk);
    in_valid = v;
    {x3, x2, x1, x0} = x;
  endtask

  initial begin
    fwd_tab = '{4'h1, 4'h3, 4'h0, 4'h2, 4'h7, 4'hE, 4'h4, 4'hD,
                4'h9, 4'hB, 4'h8, 4'hA, 4'hF, 4'h6, 4'hC, 4'h5};
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    {x3, x2, x1, x0} = 4'h0;
`ifdef FUTURE_SB_INVERSE_EN
    inv = 1'b0;
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", y_bus(), 4'h0);
    check("reset_valid", {3'b0, out_valid}, 4'h1 & 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // exhaustive forward sweep with expected queue
    seen = '0;
    repeats = 0;
    drive(1'b1, 4'h0);
    exp_q.push_back(fwd_tab[0]);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("sweep_queue_empty", 4'h1, 4'h0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check($sformatf("sweep_y_%0d", i - 1), y_bus(), e);
        check($sformatf("sweep_valid_%0d", i - 1), {3'b0, out_valid}, 4'h1);
        if (seen[y_bus()]) repeats++;
        seen[y_bus()] = 1'b1;
      end
      if (i < 16) begin
        {x3, x2, x1, x0} = 4'(i);
        exp_q.push_back(fwd_tab[i]);
      end else begin
        in_valid = 1'b0;
      end
    end

    // bijection over the observed forward outputs
    checks++;
    if (seen !== 16'hFFFF || repeats != 0) begin
      errors++;
      $display("FAIL bijection: seen %h repeats %0d expected seen ffff repeats 0", seen, repeats);
    end

    // hold: load 5 -> E, then idle with toggling x
    drive(1'b1, 4'h5);
    drive(1'b0, 4'hA);
    check("hold_load_y", y_bus(), 4'hE);
    check("hold_load_valid", {3'b0, out_valid}, 4'h1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'($urandom_range(0, 15)));
      check($sformatf("hold_y_%0d", k), y_bus(), 4'hE);
      check($sformatf("hold_valid_%0d", k), {3'b0, out_valid}, 4'h0);
    end
    drive(1'b0, 4'h0);
    x2 = 1'bx;
    @(negedge clk);
    check("hold_x_input_y", y_bus(), 4'hE);

    // back-to-back: 0 then F, no bubble
    drive(1'b1, 4'h0);
    drive(1'b1, 4'hF);
    check("b2b_first_y", y_bus(), 4'h1);
    check("b2b_first_valid", {3'b0, out_valid}, 4'h1);
    drive(1'b0, 4'h0);
    check("b2b_second_y", y_bus(), 4'h5);
    check("b2b_second_valid", {3'b0, out_valid}, 4'h1);

    // asynchronous reset mid-stream with y=E
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h3);
    check("pre_reset_y", y_bus(), 4'hE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_y", y_bus(), 4'h0);
    check("async_reset_valid", {3'b0, out_valid}, 4'h0);
    @(negedge clk);
    check("reset_held_y", y_bus(), 4'h0);
    rst_n = 1'b1;
    {x3, x2, x1, x0} = 4'h9;
    in_valid = 1'b1;
    @(negedge clk);
    check("post_reset_y", y_bus(), 4'hB);
    check("post_reset_valid", {3'b0, out_valid}, 4'h1);
    in_valid = 1'b0;

`ifdef FUTURE_SB_INVERSE_EN
    // inverse spot value and round trip
    @(negedge clk);
    inv = 1'b1;
    in_valid = 1'b1;
    {x3, x2, x1, x0} = 4'hE;
    @(negedge clk);
    in_valid = 1'b0;
    check("inv_E", y_bus(), 4'h5);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] fwd_y;
      inv = 1'b0;
      in_valid = 1'b1;
      {x3, x2, x1, x0} = 4'(i);
      @(negedge clk);
      fwd_y = y_bus();
      check($sformatf("rt_fwd_%0d", i), fwd_y, fwd_tab[i]);
      inv = 1'b1;
      {x3, x2, x1, x0} = fwd_y;
      @(negedge clk);
      check($sformatf("rt_inv_%0d", i), y_bus(), 4'(i));
    end
    in_valid = 1'b0;
    inv = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
